// File: rtl/door_motor_driver_if.sv
// Bundles the opener FSM's direction requests, the limit sensors and the
// motor driver's relay/status outputs into one connection.
interface door_motor_driver_if;
  logic       u;
  logic       d;
  logic       c;
  logic       o;
  logic       m_up;
  logic       m_dn;
  logic       brake;
  logic       fault;
  logic [2:0] MState;

  // Upstream side: supplies requests and sensors, observes the motor driver.
  modport master (
    output u, d, c, o,
    input  m_up, m_dn, brake, fault, MState
  );

  // Motor driver side.
  modport slave (
    input  u, d, c, o,
    output m_up, m_dn, brake, fault, MState
  );
endinterface

// File: rtl/door_motor_driver.sv
// Garage-door motor relay driver. Turns up/down requests into relay drive
// with a brake, a forced dead time after every run, limit-switch cutoff and
// a sticky travel-timeout fault that only reset clears.
module door_motor_driver #(
  parameter int DEAD_TIME = 4,
  parameter int TIMEOUT   = 64
) (
  input logic                 clk,
  input logic                 r,
  door_motor_driver_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN_UP = 3'd1,
    RUN_DN = 3'd2,
    DEAD   = 3'd3,
    FAULT  = 3'd4
  } state_t;

  localparam int MAX_COUNT = (TIMEOUT > DEAD_TIME) ? TIMEOUT : DEAD_TIME;
  localparam int CW        = $clog2(MAX_COUNT + 1);

  localparam logic [CW-1:0] RUN_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_TIME - 1);

  state_t        r_state;
  state_t        w_nextState;
  logic [CW-1:0] r_cnt;
  logic          w_counting;

  logic          w_mUp;
  logic          w_mDn;
  logic          w_brake;
  logic          w_fault;

  // State and cycle counter; the counter restarts on every state change so
  // it always measures time spent in the current state.
  always_ff @(posedge clk) begin
    if (r) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState != r_state) begin
        r_cnt <= '0;
      end else if (w_counting) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Next-state decision; a stop or limit condition is checked before the
  // timeout so a door reaching its limit on the last allowed cycle stops
  // cleanly instead of faulting. Simultaneous u and d never starts a run.
  always_comb begin
    w_nextState = r_state;
    w_counting  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.u && !bus.d && !bus.o) begin
          w_nextState = RUN_UP;
        end else if (bus.d && !bus.u && !bus.c) begin
          w_nextState = RUN_DN;
        end
      end
      RUN_UP: begin
        w_counting = 1'b1;
        if (!bus.u || bus.d || bus.o) begin
          w_nextState = DEAD;
        end else if (r_cnt == RUN_LAST) begin
          w_nextState = FAULT;
        end
      end
      RUN_DN: begin
        w_counting = 1'b1;
        if (!bus.d || bus.u || bus.c) begin
          w_nextState = DEAD;
        end else if (r_cnt == RUN_LAST) begin
          w_nextState = FAULT;
        end
      end
      DEAD: begin
        w_counting = 1'b1;
        if (r_cnt == DEAD_LAST) begin
          w_nextState = IDLE;
        end
      end
      FAULT: begin
        w_nextState = FAULT;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Moore output decode; the brake is engaged whenever neither relay is
  // driven, and the two relays come from disjoint states so they can never
  // be energised together.
  always_comb begin
    w_mUp   = 1'b0;
    w_mDn   = 1'b0;
    w_brake = 1'b1;
    w_fault = 1'b0;
    case (r_state)
      RUN_UP: begin
        w_mUp   = 1'b1;
        w_brake = 1'b0;
      end
      RUN_DN: begin
        w_mDn   = 1'b1;
        w_brake = 1'b0;
      end
      FAULT: begin
        w_fault = 1'b1;
      end
      default: begin
        w_mUp   = 1'b0;
      end
    endcase
  end

  assign bus.m_up   = w_mUp;
  assign bus.m_dn   = w_mDn;
  assign bus.brake  = w_brake;
  assign bus.fault  = w_fault;
  assign bus.MState = r_state;

endmodule

// File: tb/tb_door_motor_driver.sv
// Self-checking bench for door_motor_driver: a reference model predicts the
// Moore outputs for every driven cycle, queues them, and each cycle's DUT
// outputs are popped against the queue. Directed sequences cover reversal
// timing, timeout length, limit-vs-timeout priority and reset mid-run.
module tb_door_motor_driver;

  localparam int DEAD_TIME = 4;
  localparam int TIMEOUT   = 64;

  logic clk;
  logic r;

  door_motor_driver_if bus ();

  door_motor_driver #(
    .DEAD_TIME (DEAD_TIME),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  int vecCount = 0;
  int errCount = 0;

  // Reference model state: 0 idle, 1 up, 2 down, 3 dead, 4 fault.
  int mSt  = 0;
  int mCnt = 0;

  logic [6:0] expQ[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] expVec(input int st);
    logic [6:0] v;
    case (st)
      0:       v = {1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
      1:       v = {1'b1, 1'b0, 1'b0, 1'b0, 3'd1};
      2:       v = {1'b0, 1'b1, 1'b0, 1'b0, 3'd2};
      3:       v = {1'b0, 1'b0, 1'b1, 1'b0, 3'd3};
      default: v = {1'b0, 1'b0, 1'b1, 1'b1, 3'd4};
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [6:0] act, input logic [6:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic iu, input logic id,
                               input logic ic, input logic io, input string tag);
    int nxt;
    logic [6:0] obs;
    r     = rst;
    bus.u = iu;
    bus.d = id;
    bus.c = ic;
    bus.o = io;
    nxt = mSt;
    if (rst) begin
      nxt = 0;
    end else if (mSt == 0) begin
      if (iu && !id && !io)      nxt = 1;
      else if (id && !iu && !ic) nxt = 2;
    end else if (mSt == 1) begin
      if (!iu || id || io)       nxt = 3;
      else if (mCnt == TIMEOUT - 1) nxt = 4;
    end else if (mSt == 2) begin
      if (!id || iu || ic)       nxt = 3;
      else if (mCnt == TIMEOUT - 1) nxt = 4;
    end else if (mSt == 3) begin
      if (mCnt == DEAD_TIME - 1) nxt = 0;
    end
    if (rst || nxt != mSt)                     mCnt = 0;
    else if (mSt == 1 || mSt == 2 || mSt == 3) mCnt = mCnt + 1;
    mSt = nxt;
    expQ.push_back(expVec(mSt));
    @(posedge clk);
    #1;
    obs = {bus.m_up, bus.m_dn, bus.brake, bus.fault, bus.MState};
    checkOutput(tag, obs, expQ.pop_front());
    if (bus.m_up && bus.m_dn) begin
      checkOutput("relayExclusive", 7'd1, 7'd0);
    end
  endtask

  initial begin
    int edges;
    int hiCycles;
    logic ru, rd, rc, ro, rr;

    r     = 1'b1;
    bus.u = 1'b0;
    bus.d = 1'b0;
    bus.c = 1'b0;
    bus.o = 1'b0;

    // Reset and idle.
    applyStimulus(1, 0, 0, 0, 0, "reset");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, "idle");

    // Open from closed, then hit the open limit.
    applyStimulus(0, 1, 0, 1, 0, "startUp");
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, 0, "runUp");
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 0, 1, "openLimit");

    // Reversal: up run, then switch to down.
    applyStimulus(1, 0, 0, 0, 0, "reset2");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, "revUp");
    applyStimulus(0, 0, 1, 0, 0, "revStop");
    checkOutput("revUpOff", {6'd0, bus.m_up}, 7'd0);
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 1, 0, 0, "revWait");
      edges++;
      if (bus.m_dn) break;
    end
    checkOutput("revDelay", 7'(edges), 7'd5);

    // Stalled close: drive length and sticky fault.
    applyStimulus(1, 0, 0, 0, 0, "reset3");
    hiCycles = 0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(0, 0, 1, 0, 0, "stall");
      if (bus.m_dn) hiCycles++;
      if (bus.fault) break;
    end
    checkOutput("driveLength", 7'(hiCycles), 7'd64);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0, "faultHold");
    applyStimulus(1, 1, 0, 0, 0, "faultReset");
    applyStimulus(0, 0, 0, 0, 0, "afterFault");

    // Requests into an active limit, and the illegal u&d pair.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0, "dnAtClosed");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 1, "upAtOpen");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 0, "bothReq");

    // Reset mid-run goes straight to idle without a dead period.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, "preReset");
    applyStimulus(1, 0, 1, 0, 0, "midRunReset");
    checkOutput("midRunResetState", {4'd0, bus.MState}, 7'd0);
    applyStimulus(0, 0, 1, 0, 0, "rerun");

    // Limit and timeout in the same cycle: limit wins.
    applyStimulus(1, 0, 0, 0, 0, "reset4");
    applyStimulus(0, 0, 1, 0, 0, "edgeStart");
    for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(0, 0, 1, 0, 0, "edgeRun");
    applyStimulus(0, 0, 1, 1, 0, "edgeLimit");
    checkOutput("limitBeatsTimeout", {4'd0, bus.MState}, 7'd3);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, "edgeSettle");

    // Random traffic with occasional reset.
    ru = 0; rd = 0; rc = 0; ro = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        ru = 1'($urandom_range(0, 1));
        rd = 1'($urandom_range(0, 1));
        rc = ($urandom_range(0, 3) == 0);
        ro = ($urandom_range(0, 3) == 0);
      end
      rr = ($urandom_range(0, 59) == 0);
      applyStimulus(rr, ru, rd, rc, ro, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
